stream_packer: RTL and testbench
================================

// Module: stream_packer
// PURPOSE
//  Width upsizer placed directly downstream of fifo_pointers. Consumes narrow
//  WIDTH-bit words over a valid/ack handshake and emits one WIDTH*RATIO-bit beat
//  per RATIO words, or a shorter partial beat when in_last closes a group early.
//  Sustains one input word per cycle under no backpressure.
// PARAMETERS
//  WIDTH  32  input word width in bits (>=1)
//  RATIO  4   input words per output beat (>=1; RATIO=1 behaves as a register slice)
// PORTS
//  clock      in   1             rising-edge clock
//  reset      in   1             asynchronous, active-high reset
//  in         in   WIDTH         input word
//  in_valid   in   1             input word present
//  in_last    in   1             closes the current beat after this word
//  in_ack     out  1             block accepts input this cycle
//  out        out  WIDTH*RATIO   packed beat; lane i = out[i*WIDTH +: WIDTH]
//  out_count  out  $clog2(RATIO+1)  valid lanes in beat, 1..RATIO
//  out_last   out  1             beat was closed by in_last
//  out_valid  out  1             beat present
//  out_ack    in   1             downstream accepts beat
// BEHAVIOUR
//  Handshake: transfer on a port iff valid && ack in the same cycle.
//  - Producer holds in/in_valid/in_last stable until accepted.
//  - The block holds out/out_count/out_last stable while out_valid && !out_ack.
//  Reset (async, any cycle): out_valid=0, out=0, out_count=0, out_last=0,
//  lane index=0, state=FILL; in_ack=0 while reset high. Partial data discarded.
//  State: FILL (assembling; out_valid=0) / HOLD (beat complete; out_valid=1).
//  Lane index idx: 0..RATIO-1, register width $clog2(RATIO) (min 1 bit).
//  in_ack: FILL -> 1; HOLD -> out_ack (combinational pass-through for zero bubbles).
//  FILL, input accepted:
//  - idx==0: clear all lanes, write lane 0.
//  - else write lane idx; other lanes unchanged.
//  - idx==RATIO-1 or in_last: go HOLD, out_count=idx+1, out_last=in_last, idx=0.
//  - else idx<=idx+1.
//  HOLD:
//  - out_ack=0: no change.
//  - out_ack=1 with no input: go FILL, out_valid=0.
//  - out_ack=1 with input: beat consumed and input written to lane 0 of a fresh
//    beat (others cleared) in the same cycle. If RATIO==1 or in_last, stay HOLD
//    with out_count=1 and the new out_last; else go FILL with idx=1.
//  Unwritten lanes of a partial beat read as zero.
//  Latency: out_valid rises the cycle after the edge accepting the closing word.
//  Throughput: 1 word/cycle when out_ack is held at 1; beat every RATIO cycles.
//  in_last on the RATIO-th word: full beat, out_count=RATIO, out_last=1.
//  No word dropped or duplicated; output order equals input order.
//  Accepted words == sum of out_count over accepted beats (ignoring reset flushes).
// TESTING (WIDTH=8, RATIO=4 unless noted)
//  1 In 11,22,33,44 back-to-back, out_ack=1 -> out=0x44332211, count=4, last=0,
//    out_valid for exactly 1 cycle, starting the cycle after 44 is accepted.
//  2 In AA, then BB with in_last -> out=0x0000BBAA, count=2, last=1.
//  3 Beat held, out_ack=0 for 5 cycles, in_valid=1 with 55 -> in_ack=0 and out
//    stable for all 5 cycles; out_ack=1 -> beat consumed, 55 accepted into lane 0
//    the same cycle.
//  4 Words 01..08 streamed, out_ack=1 throughout -> in_ack=1 on all 8 cycles;
//    beats 0x04030201 then 0x08070605.
//  5 Accept 2 words, pulse reset mid-fill -> out_valid=0 immediately; next
//    C1..C4 -> out=0xC4C3C2C1, count=4 (no stale lanes).
//  6 RATIO=1: in 7E, 7F consecutive, out_ack=1 -> beats 0x7E then 0x7F,
//    count=1 each, no bubbles.

Source files
------------

// File: rtl/stream_packer_if.sv
// Handshake bundle for stream_packer: narrow word stream in,
// packed wide beat stream out.
interface stream_packer_if #(
  parameter int WIDTH = 32,
  parameter int RATIO = 4
);
  localparam int CW = $clog2(RATIO + 1);

  logic [WIDTH-1:0]       in;
  logic                   in_valid;
  logic                   in_last;
  logic                   in_ack;
  logic [WIDTH*RATIO-1:0] out;
  logic [CW-1:0]          out_count;
  logic                   out_last;
  logic                   out_valid;
  logic                   out_ack;

  modport master (
    output in, in_valid, in_last, out_ack,
    input  in_ack, out, out_count, out_last, out_valid
  );

  modport slave (
    input  in, in_valid, in_last, out_ack,
    output in_ack, out, out_count, out_last, out_valid
  );
endinterface

// File: rtl/stream_packer.sv
// Width upsizer: packs RATIO narrow words into one wide beat,
// closing early on in_last.
module stream_packer #(
  parameter int WIDTH = 32,
  parameter int RATIO = 4
) (
  input logic            clock,
  input logic            reset,
  stream_packer_if.slave bus
);
  localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int CW = $clog2(RATIO + 1);
  localparam int DW = WIDTH * RATIO;

  localparam logic [0:0]    FILL    = 1'b0;
  localparam logic [0:0]    HOLD    = 1'b1;
  localparam logic [IW-1:0] IDX_MAX = IW'(RATIO - 1);

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic          acc;

  // HOLD passes out_ack straight through so a new word can
  // enter on the same edge the held beat leaves.
  assign bus.in_ack = !reset && ((state_q == FILL) || bus.out_ack);
  assign acc        = bus.in_valid && bus.in_ack;

  assign bus.out       = data_q;
  assign bus.out_count = cnt_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (1'b1)
      (state_q == FILL): begin
        if (acc) begin
          if (idx_q == '0) data_d = '0;
          data_d[idx_q*WIDTH +: WIDTH] = bus.in;
          if (idx_q == IDX_MAX || bus.in_last) begin
            state_d = HOLD;
            cnt_d   = CW'(idx_q) + CW'(1);
            last_d  = bus.in_last;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      (state_q == HOLD): begin
        if (bus.out_ack) begin
          if (acc) begin
            data_d              = '0;
            data_d[WIDTH-1:0]   = bus.in;
            if (RATIO == 1 || bus.in_last) begin
              cnt_d  = CW'(1);
              last_d = bus.in_last;
            end else begin
              state_d = FILL;
              idx_d   = IW'(1);
            end
          end else begin
            state_d = FILL;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_stream_packer.sv
// Bench for stream_packer: queue-based packing model plus
// directed scenarios with literal expectations.
module tb_stream_packer;
  localparam int W = 8;
  localparam int R = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  stream_packer_if #(.WIDTH(W), .RATIO(R)) bus ();
  stream_packer_if #(.WIDTH(W), .RATIO(1)) bus1 ();

  stream_packer #(.WIDTH(W), .RATIO(R)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  stream_packer #(.WIDTH(W), .RATIO(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [W*R-1:0] data;
    int             cnt;
    logic           last;
  } beat_t;

  beat_t          expq[$];
  beat_t          got_log[$];
  logic [W-1:0]   part[$];

  logic [W*R-1:0] prev_out;
  int             prev_cnt;
  logic           prev_last;
  logic           prev_hold = 1'b0;

  // Reference model: collect accepted words, close a group after R
  // words or on in_last, and compare against beats handed downstream.
  always @(negedge clock) begin
    beat_t b, e;
    if (reset) begin
      part.delete();
      prev_hold = 1'b0;
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out", 64'(bus.out), 64'd0);
      chk("rst_count", 64'(bus.out_count), 64'd0);
      chk("rst_last", 64'(bus.out_last), 64'd0);
      chk("rst_in_ack", 64'(bus.in_ack), 64'd0);
    end else begin
      chk("in_ack_rule", 64'(bus.in_ack),
          64'(!bus.out_valid || bus.out_ack));
      if (prev_hold) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_out", 64'(bus.out), 64'(prev_out));
        chk("hold_cnt", 64'(bus.out_count), 64'(prev_cnt));
        chk("hold_last", 64'(bus.out_last), 64'(prev_last));
      end
      if (bus.out_valid && bus.out_ack) begin
        b.data = bus.out;
        b.cnt  = int'(bus.out_count);
        b.last = bus.out_last;
        got_log.push_back(b);
        if (expq.size() == 0) begin
          chk("unexpected_beat", 64'(b.data), 64'd0);
          n_bad++;
          $display("FAIL beat_order: got beat with no expected beat");
        end else begin
          e = expq.pop_front();
          chk("beat_data", 64'(b.data), 64'(e.data));
          chk("beat_cnt", 64'(b.cnt), 64'(e.cnt));
          chk("beat_last", 64'(b.last), 64'(e.last));
        end
      end
      prev_hold = bus.out_valid && !bus.out_ack;
      prev_out  = bus.out;
      prev_cnt  = int'(bus.out_count);
      prev_last = bus.out_last;
      if (bus.in_valid && bus.in_ack) begin
        part.push_back(bus.in);
        if (part.size() == R || bus.in_last) begin
          e.data = '0;
          for (int i = 0; i < part.size(); i++)
            e.data[i*W +: W] = part[i];
          e.cnt  = part.size();
          e.last = bus.in_last;
          expq.push_back(e);
          part.delete();
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] w, input logic lst,
                      output int waits);
    waits = 0;
    bus.in       = w;
    bus.in_last  = lst;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clock);
      if (bus.in_ack) break;
      waits++;
      if (waits > 50) begin
        $display("FAIL send_timeout: got no in_ack want in_ack");
        n_bad++;
        break;
      end
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    int wt;
    reset         = 1'b1;
    bus.in        = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ack   = 1'b1;
    bus1.in       = '0;
    bus1.in_valid = 1'b0;
    bus1.in_last  = 1'b0;
    bus1.out_ack  = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    // 1: full beat, single-cycle valid
    send(8'h11, 1'b0, wt);
    send(8'h22, 1'b0, wt);
    send(8'h33, 1'b0, wt);
    send(8'h44, 1'b0, wt);
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_out", 64'(bus.out), 64'h44332211);
    chk("t1_cnt", 64'(bus.out_count), 64'd4);
    chk("t1_last", 64'(bus.out_last), 64'd0);
    @(posedge clock);
    #1;
    chk("t1_valid_drop", 64'(bus.out_valid), 64'd0);

    // 2: partial beat closed by in_last
    send(8'hAA, 1'b0, wt);
    send(8'hBB, 1'b1, wt);
    chk("t2_out", 64'(bus.out), 64'h0000BBAA);
    chk("t2_cnt", 64'(bus.out_count), 64'd2);
    chk("t2_last", 64'(bus.out_last), 64'd1);
    @(posedge clock);
    #1;

    // 3: backpressure, then consume and accept in one cycle
    bus.out_ack = 1'b0;
    send(8'h01, 1'b0, wt);
    send(8'h02, 1'b0, wt);
    send(8'h03, 1'b0, wt);
    send(8'h04, 1'b0, wt);
    bus.in       = 8'h55;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t3_in_ack", 64'(bus.in_ack), 64'd0);
      chk("t3_out", 64'(bus.out), 64'h04030201);
    end
    @(posedge clock);
    #1 bus.out_ack = 1'b1;
    @(negedge clock);
    chk("t3_ack_pass", 64'(bus.in_ack), 64'd1);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    chk("t3_fill", 64'(bus.out_valid), 64'd0);
    send(8'h66, 1'b1, wt);
    chk("t3_out2", 64'(bus.out), 64'h00006655);
    chk("t3_cnt2", 64'(bus.out_count), 64'd2);

    // 4: streaming without bubbles
    for (int i = 1; i <= 8; i++) begin
      send(W'(i), 1'b0, wt);
      chk("t4_no_stall", 64'(wt), 64'd0);
    end
    @(posedge clock);
    #1;
    chk("t4_log_n", 64'(got_log.size()), 64'd6);
    if (got_log.size() >= 6) begin
      chk("t4_beat0", 64'(got_log[4].data), 64'h04030201);
      chk("t4_beat1", 64'(got_log[5].data), 64'h08070605);
    end

    // 5: reset mid-fill discards partial data
    send(8'hA1, 1'b0, wt);
    send(8'hA2, 1'b0, wt);
    #1 reset = 1'b1;
    #1;
    chk("t5_valid_rst", 64'(bus.out_valid), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    send(8'hC1, 1'b0, wt);
    send(8'hC2, 1'b0, wt);
    send(8'hC3, 1'b0, wt);
    send(8'hC4, 1'b0, wt);
    chk("t5_out", 64'(bus.out), 64'hC4C3C2C1);
    chk("t5_cnt", 64'(bus.out_count), 64'd4);
    @(posedge clock);
    #1;

    // 6: RATIO=1 register slice
    bus1.in       = 8'h7E;
    bus1.in_valid = 1'b1;
    @(negedge clock);
    chk("t6_ack0", 64'(bus1.in_ack), 64'd1);
    @(posedge clock);
    #1;
    chk("t6_out0", 64'(bus1.out), 64'h7E);
    chk("t6_cnt0", 64'(bus1.out_count), 64'd1);
    bus1.in = 8'h7F;
    @(negedge clock);
    chk("t6_ack1", 64'(bus1.in_ack), 64'd1);
    @(posedge clock);
    #1;
    bus1.in_valid = 1'b0;
    chk("t6_valid1", 64'(bus1.out_valid), 64'd1);
    chk("t6_out1", 64'(bus1.out), 64'h7F);
    chk("t6_cnt1", 64'(bus1.out_count), 64'd1);
    @(posedge clock);
    #1;
    chk("t6_idle", 64'(bus1.out_valid), 64'd0);

    repeat (2) @(posedge clock);
    #1;
    chk("end_expq", 64'(expq.size()), 64'd0);
    chk("end_part", 64'(part.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
